// File: rtl/dcache_ctrl_fsm.sv
// Write-back, write-allocate data cache controller: hit/miss compare,
// dirty victim write-back, word-by-word refill, replay and statistics.
module dcache_ctrl_fsm #(
    parameter int WORDS_PER_LINE = 8,
    parameter int CNT_W          = 16,
    localparam int IW            = $clog2(WORDS_PER_LINE)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             read,
    input  logic             write,
    input  logic             hit,
    input  logic             dirty,
    input  logic             mem_ack,
    input  logic             clr_stats,
    output logic             stall,
    output logic             cache_we,
    output logic             set_dirty,
    output logic             fill_we,
    output logic             tag_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_victim,
    output logic [IW-1:0]    word_idx,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        S_COMPARE,
        S_WRITE_BACK,
        S_ALLOCATE,
        S_UPDATE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_LINE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_word_idx;
    logic [IW-1:0]    w_word_idx_next;
    logic             r_replay;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_req;
    logic             w_last;
    logic             w_hit_inc;
    logic             w_miss_inc;

    assign w_req  = read | write;
    assign w_last = (r_word_idx == LAST_IDX);

    always_comb begin
        w_next          = r_state;
        w_word_idx_next = r_word_idx;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        stall           = 1'b0;
        cache_we        = 1'b0;
        set_dirty       = 1'b0;
        fill_we         = 1'b0;
        tag_we          = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_sel_victim  = 1'b0;
        case (r_state)
            S_COMPARE: begin
                if (w_req && hit) begin
                    cache_we  = write;
                    set_dirty = write;
                    w_hit_inc = ~r_replay;
                end else if (w_req) begin
                    stall      = 1'b1;
                    w_miss_inc = ~r_replay;
                    w_next     = dirty ? S_WRITE_BACK : S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                stall          = 1'b1;
                mem_req        = 1'b1;
                mem_we         = 1'b1;
                mem_sel_victim = 1'b1;
                if (mem_ack) begin
                    w_word_idx_next = r_word_idx + 1'b1;
                    if (w_last) begin
                        w_word_idx_next = '0;
                        w_next          = S_ALLOCATE;
                    end
                end
            end
            S_ALLOCATE: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                fill_we = mem_ack;
                if (mem_ack) begin
                    w_word_idx_next = r_word_idx + 1'b1;
                    if (w_last) begin
                        w_word_idx_next = '0;
                        w_next          = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                stall  = 1'b1;
                tag_we = 1'b1;
                w_next = S_COMPARE;
            end
            default: w_next = S_COMPARE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_COMPARE;
            r_word_idx <= '0;
            r_replay   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_word_idx <= w_word_idx_next;
            r_replay   <= (r_state == S_UPDATE);
        end
    end

    // Clear wins over a coincident increment; counters stick at all-ones.
    always_ff @(posedge CLK) begin
        if (RST || clr_stats) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc && !(&r_hit_cnt))
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_miss_inc && !(&r_miss_cnt))
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign word_idx   = r_word_idx;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Bench for dcache_ctrl_fsm: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dcache_ctrl_fsm;

    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic read = 1'b0, write = 1'b0, hit = 1'b0, dirty = 1'b0;
    logic mem_ack = 1'b0, clr_stats = 1'b0;

    logic        stall, cache_we, set_dirty, fill_we, tag_we;
    logic        mem_req, mem_we, mem_sel_victim;
    logic [1:0]  word_idx;
    logic [15:0] hit_count, miss_count;

    logic        s_stall, s_cache_we, s_set_dirty, s_fill_we, s_tag_we;
    logic        s_mem_req, s_mem_we, s_mem_sel_victim;
    logic [1:0]  s_word_idx;
    logic [1:0]  s_hit_count, s_miss_count;

    always #5 CLK = ~CLK;

    dcache_ctrl_fsm #(.WORDS_PER_LINE(N), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .read(read), .write(write), .hit(hit),
        .dirty(dirty), .mem_ack(mem_ack), .clr_stats(clr_stats),
        .stall(stall), .cache_we(cache_we), .set_dirty(set_dirty),
        .fill_we(fill_we), .tag_we(tag_we), .mem_req(mem_req),
        .mem_we(mem_we), .mem_sel_victim(mem_sel_victim),
        .word_idx(word_idx), .hit_count(hit_count), .miss_count(miss_count)
    );

    dcache_ctrl_fsm #(.WORDS_PER_LINE(N), .CNT_W(2)) u_sat (
        .CLK(CLK), .RST(RST), .read(read), .write(write), .hit(hit),
        .dirty(dirty), .mem_ack(mem_ack), .clr_stats(clr_stats),
        .stall(s_stall), .cache_we(s_cache_we), .set_dirty(s_set_dirty),
        .fill_we(s_fill_we), .tag_we(s_tag_we), .mem_req(s_mem_req),
        .mem_we(s_mem_we), .mem_sel_victim(s_mem_sel_victim),
        .word_idx(s_word_idx), .hit_count(s_hit_count),
        .miss_count(s_miss_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction model: beats left to write back / refill, pending tag update.
    bit m_on = 0;
    int m_wb = 0, m_fill = 0;
    bit m_upd = 0, m_rep = 0;
    int m_hit = 0, m_miss = 0, m_hit2 = 0, m_miss2 = 0;

    always @(posedge CLK) begin
        bit inc_h, inc_m;
        inc_h = 0;
        inc_m = 0;
        if (RST) begin
            m_on = 1; m_wb = 0; m_fill = 0; m_upd = 0; m_rep = 0;
            m_hit = 0; m_miss = 0; m_hit2 = 0; m_miss2 = 0;
        end else if (m_on) begin
            if (m_wb > 0) begin
                if (mem_ack) m_wb--;
            end else if (m_fill > 0) begin
                if (mem_ack) m_fill--;
            end else if (m_upd) begin
                m_upd = 0;
                m_rep = 1;
            end else begin
                if (read || write) begin
                    if (hit) inc_h = !m_rep;
                    else begin
                        inc_m  = !m_rep;
                        m_wb   = dirty ? N : 0;
                        m_fill = N;
                        m_upd  = 1;
                    end
                end
                m_rep = 0;
            end
            if (clr_stats) begin
                m_hit = 0; m_miss = 0; m_hit2 = 0; m_miss2 = 0;
            end else begin
                if (inc_h && m_hit < 65535) m_hit++;
                if (inc_h && m_hit2 < 3) m_hit2++;
                if (inc_m && m_miss < 65535) m_miss++;
                if (inc_m && m_miss2 < 3) m_miss2++;
            end
        end
    end

    int st_cnt = 0, tw_cnt = 0, wbeats = 0, rbeats = 0;
    int fq[$];

    always @(negedge CLK) begin
        logic es, ecw, esd, efw, etw, emr, emw, esv;
        int eidx;
        if (m_on) begin
            {es, ecw, esd, efw, etw, emr, emw, esv} = '0;
            eidx = 0;
            if (m_wb > 0) begin
                es = 1; emr = 1; emw = 1; esv = 1;
                eidx = N - m_wb;
            end else if (m_fill > 0) begin
                es = 1; emr = 1; efw = mem_ack;
                eidx = N - m_fill;
            end else if (m_upd) begin
                es = 1; etw = 1;
            end else if (read || write) begin
                if (hit) begin
                    ecw = write; esd = write;
                end else es = 1;
            end
            chk("stall", 32'(stall), 32'(es));
            chk("cache_we", 32'(cache_we), 32'(ecw));
            chk("set_dirty", 32'(set_dirty), 32'(esd));
            chk("fill_we", 32'(fill_we), 32'(efw));
            chk("tag_we", 32'(tag_we), 32'(etw));
            chk("mem_req", 32'(mem_req), 32'(emr));
            chk("mem_we", 32'(mem_we), 32'(emw));
            chk("mem_sel_victim", 32'(mem_sel_victim), 32'(esv));
            chk("word_idx", 32'(word_idx), 32'(eidx));
            chk("hit_count", 32'(hit_count), 32'(m_hit));
            chk("miss_count", 32'(miss_count), 32'(m_miss));
            chk("sat_stall", 32'(s_stall), 32'(es));
            chk("sat_word_idx", 32'(s_word_idx), 32'(eidx));
            chk("sat_hit_count", 32'(s_hit_count), 32'(m_hit2));
            chk("sat_miss_count", 32'(s_miss_count), 32'(m_miss2));
            if (stall) st_cnt++;
            if (tag_we) tw_cnt++;
            if (fill_we) fq.push_back(int'(word_idx));
            if (mem_req && mem_ack && mem_we) wbeats++;
            if (mem_req && mem_ack && !mem_we) rbeats++;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue a miss, run it to UPDATE, then replay with hit=1.
    task automatic run_miss(input logic w, input logic d, input logic gap);
        bit done;
        done = 0;
        st_cnt = 0; tw_cnt = 0; wbeats = 0; rbeats = 0;
        fq.delete();
        read = !w; write = w; hit = 0; dirty = d; mem_ack = 1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge CLK);
            if (tag_we) done = 1;
            else begin
                step();
                if (gap) mem_ack = ~mem_ack;
            end
        end
        chk("miss_reaches_update", 32'(done), 32'd1);
        step();
        hit = 1; mem_ack = 0; dirty = 0;
        @(negedge CLK);
        chk("replay_stall", 32'(stall), 32'd0);
        chk("replay_cache_we", 32'(cache_we), 32'(w));
        step();
        read = 0; write = 0; hit = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 0;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_word_idx", 32'(word_idx), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);

        read = 1; hit = 1;
        @(negedge CLK);
        chk("s1_stall", 32'(stall), 32'd0);
        chk("s1_mem_req", 32'(mem_req), 32'd0);
        step();
        read = 0; hit = 0;
        chk("s1_hit_count", 32'(hit_count), 32'd1);

        write = 1; hit = 1;
        @(negedge CLK);
        chk("s2_cache_we", 32'(cache_we), 32'd1);
        chk("s2_set_dirty", 32'(set_dirty), 32'd1);
        chk("s2_stall", 32'(stall), 32'd0);
        step();
        write = 0; hit = 0;
        chk("s2_miss_count", 32'(miss_count), 32'd0);
        chk("s2_hit_count", 32'(hit_count), 32'd2);

        run_miss(1'b0, 1'b0, 1'b0);
        chk("s3_stall_cycles", 32'(st_cnt), 32'd6);
        chk("s3_fill_pulses", 32'(fq.size()), 32'd4);
        if (fq.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("s3_fill_idx", 32'(fq[i]), 32'(i));
        chk("s3_tag_we_cycles", 32'(tw_cnt), 32'd1);
        chk("s3_miss_count", 32'(miss_count), 32'd1);
        chk("s3_hit_count", 32'(hit_count), 32'd2);

        run_miss(1'b1, 1'b1, 1'b1);
        chk("s4_write_beats", 32'(wbeats), 32'd4);
        chk("s4_read_beats", 32'(rbeats), 32'd4);
        chk("s4_fill_pulses", 32'(fq.size()), 32'd4);
        chk("s4_miss_count", 32'(miss_count), 32'd2);
        chk("s4_hit_count", 32'(hit_count), 32'd2);

        read = 1; hit = 0; dirty = 0; mem_ack = 1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (word_idx == 2'd2 && mem_req && !mem_we) break;
        end
        chk("s5_at_word2", 32'(word_idx), 32'd2);
        RST = 1; read = 0; mem_ack = 0;
        step();
        RST = 0;
        chk("s5_mem_req", 32'(mem_req), 32'd0);
        chk("s5_stall", 32'(stall), 32'd0);
        chk("s5_word_idx", 32'(word_idx), 32'd0);
        chk("s5_hit_count", 32'(hit_count), 32'd0);
        chk("s5_miss_count", 32'(miss_count), 32'd0);

        read = 1; hit = 1;
        repeat (5) step();
        read = 0; hit = 0;
        chk("s6_sat_hit", 32'(s_hit_count), 32'd3);
        chk("s6_wide_hit", 32'(hit_count), 32'd5);
        clr_stats = 1; read = 1; hit = 1;
        step();
        clr_stats = 0; read = 0; hit = 0;
        chk("s6_clr_sat", 32'(s_hit_count), 32'd0);
        chk("s6_clr_wide", 32'(hit_count), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
